// File: rtl/bp_be_pkg.sv
// Shared backend types for the late-writeback path: producer ids, buffered entry
// layout and a pointer-width helper used by the arbiter and its selector.
package bp_be_pkg;

    localparam int unsigned late_wb_data_width_gp = 64;

    typedef enum logic [1:0] {
        e_late_wb_idiv = 2'd0,
        e_late_wb_fdiv = 2'd1,
        e_late_wb_mem  = 2'd2
    } bp_be_late_wb_src_e;

    typedef struct packed {
        logic                             ird_w_v;
        logic                             frd_w_v;
        logic [4:0]                       rd_addr;
        logic [4:0]                       fflags;
        logic [late_wb_data_width_gp-1:0] data;
    } bp_be_late_wb_entry_s;

    function automatic int unsigned late_wb_ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_be_late_wb_arbiter_if.sv
// Producer handshake plus late-writeback packet bundle for bp_be_late_wb_arbiter.
interface bp_be_late_wb_arbiter_if #(
    parameter int unsigned num_req_p    = 3,
    parameter int unsigned data_width_p = 64
);
    logic [num_req_p-1:0]              req_v_i;
    logic [num_req_p-1:0]              req_ready_and_o;
    logic [num_req_p-1:0]              req_ird_w_v_i;
    logic [num_req_p-1:0]              req_frd_w_v_i;
    logic [num_req_p*5-1:0]            req_rd_addr_i;
    logic [num_req_p*5-1:0]            req_fflags_i;
    logic [num_req_p*data_width_p-1:0] req_data_i;
    logic                              iwb_port_busy_i;
    logic                              fwb_port_busy_i;
    logic                              late_wb_v_o;
    logic                              late_wb_ird_w_v_o;
    logic                              late_wb_frd_w_v_o;
    logic [4:0]                        late_wb_rd_addr_o;
    logic [4:0]                        late_wb_fflags_o;
    logic [data_width_p-1:0]           late_wb_data_o;
    logic                              late_wb_yumi_o;
    logic [num_req_p-1:0]              late_wb_grant_o;
    logic                              wb_stall_o;

    modport slave (
        input  req_v_i, req_ird_w_v_i, req_frd_w_v_i, req_rd_addr_i, req_fflags_i,
               req_data_i, iwb_port_busy_i, fwb_port_busy_i,
        output req_ready_and_o, late_wb_v_o, late_wb_ird_w_v_o, late_wb_frd_w_v_o,
               late_wb_rd_addr_o, late_wb_fflags_o, late_wb_data_o, late_wb_yumi_o,
               late_wb_grant_o, wb_stall_o
    );

    modport master (
        output req_v_i, req_ird_w_v_i, req_frd_w_v_i, req_rd_addr_i, req_fflags_i,
               req_data_i, iwb_port_busy_i, fwb_port_busy_i,
        input  req_ready_and_o, late_wb_v_o, late_wb_ird_w_v_o, late_wb_frd_w_v_o,
               late_wb_rd_addr_o, late_wb_fflags_o, late_wb_data_o, late_wb_yumi_o,
               late_wb_grant_o, wb_stall_o
    );

endinterface

// File: rtl/bp_be_late_wb_rr_sel.sv
// Combinational one-hot selector: lowest starved index wins outright, otherwise
// round-robin among eligible entries starting just after last_grant.
module bp_be_late_wb_rr_sel
    import bp_be_pkg::*;
#(
    parameter int unsigned num_req_p = 3
) (
    input  logic [num_req_p-1:0]                          elig,
    input  logic [num_req_p-1:0]                          starved,
    input  logic [late_wb_ptr_width(num_req_p)-1:0]       last_grant,
    output logic [num_req_p-1:0]                          grant
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (!found && starved[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // last_grant < num_req_p, so a single subtraction wraps the rotated index
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            idx = 32'(last_grant) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Late-writeback arbiter: one buffered result per long-latency producer, at most
// one grant per cycle onto the shared RF late-write port, with starvation stall.
module bp_be_late_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter int unsigned num_req_p      = 3,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned starve_limit_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bp_be_late_wb_arbiter_if.slave       wb
);

    localparam int unsigned                ptr_width_lp   = late_wb_ptr_width(num_req_p);
    localparam logic [7:0]                 starve_limit_lp = 8'(starve_limit_p);
    localparam logic [ptr_width_lp-1:0]    last_reset_lp  = ptr_width_lp'(num_req_p - 1);

    bp_be_late_wb_entry_s        buf_r [num_req_p];
    logic [num_req_p-1:0]        buf_v_r;
    logic [7:0]                  wait_cnt [num_req_p];
    logic [ptr_width_lp-1:0]     last_grant_r;

    logic [num_req_p-1:0]        elig;
    logic [num_req_p-1:0]        starved;
    logic [num_req_p-1:0]        grant;
    logic [num_req_p-1:0]        ready;
    logic [num_req_p-1:0]        xfer;
    logic [ptr_width_lp-1:0]     grant_idx;
    bp_be_late_wb_entry_s        sel_entry;
    logic                        stall;

    always_comb begin
        elig    = '0;
        starved = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            elig[i]    = buf_v_r[i]
                       & ~(buf_r[i].ird_w_v & wb.iwb_port_busy_i)
                       & ~(buf_r[i].frd_w_v & wb.fwb_port_busy_i);
            starved[i] = elig[i] & (wait_cnt[i] == starve_limit_lp);
        end
    end

    bp_be_late_wb_rr_sel #(
        .num_req_p (num_req_p)
    ) rr_sel (
        .elig       (elig),
        .starved    (starved),
        .last_grant (last_grant_r),
        .grant      (grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_entry = '0;
        stall     = 1'b0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (grant[i]) begin
                grant_idx = ptr_width_lp'(i);
                sel_entry = buf_r[i];
            end
            stall = stall | (buf_v_r[i] & (wait_cnt[i] == starve_limit_lp));
        end
    end

    assign ready = ~buf_v_r | grant;
    assign xfer  = wb.req_v_i & ready;

    assign wb.req_ready_and_o   = ready;
    assign wb.late_wb_v_o       = |grant;
    assign wb.late_wb_yumi_o    = |grant;
    assign wb.late_wb_grant_o   = grant;
    assign wb.late_wb_ird_w_v_o = sel_entry.ird_w_v;
    assign wb.late_wb_frd_w_v_o = sel_entry.frd_w_v;
    assign wb.late_wb_rd_addr_o = sel_entry.rd_addr;
    assign wb.late_wb_fflags_o  = sel_entry.fflags;
    assign wb.late_wb_data_o    = sel_entry.data;
    assign wb.wb_stall_o        = stall;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            buf_v_r      <= '0;
            last_grant_r <= last_reset_lp;
            for (int unsigned i = 0; i < num_req_p; i++) wait_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < num_req_p; i++) begin
                // a transfer only happens into an empty or just-granted slot, so it also restarts the count
                if (grant[i] || xfer[i]) begin
                    wait_cnt[i] <= '0;
                end else if (buf_v_r[i] && (wait_cnt[i] != starve_limit_lp)) begin
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end
                if (xfer[i]) begin
                    buf_v_r[i] <= 1'b1;
                end else if (grant[i]) begin
                    buf_v_r[i] <= 1'b0;
                end
            end
            if (|grant) last_grant_r <= grant_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (xfer[i]) begin
                buf_r[i] <= '{ird_w_v: wb.req_ird_w_v_i[i],
                              frd_w_v: wb.req_frd_w_v_i[i],
                              rd_addr: wb.req_rd_addr_i[i*5 +: 5],
                              fflags:  wb.req_fflags_i[i*5 +: 5],
                              data:    wb.req_data_i[i*data_width_p +: data_width_p]};
            end
        end
    end

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Scoreboard bench for bp_be_late_wb_arbiter: a behavioural model predicts each
// cycle's outputs, directed scenarios add fixed expectations, then random traffic.
module tb_bp_be_late_wb_arbiter;

    localparam int unsigned N     = 3;
    localparam int unsigned W     = 64;
    localparam int          LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_be_late_wb_arbiter_if #(.num_req_p(N), .data_width_p(W)) ifc ();

    bp_be_late_wb_arbiter #(
        .num_req_p      (N),
        .data_width_p   (W),
        .starve_limit_p (LIMIT)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .wb        (ifc)
    );

    typedef struct {
        logic [2:0]  grant;
        logic [2:0]  ready;
        logic        v;
        logic        yumi;
        logic        ird;
        logic        frd;
        logic        stall;
        logic [4:0]  rd;
        logic [4:0]  ff;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t snap;
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    logic        m_v    [3];
    logic        m_ird  [3];
    logic        m_frd  [3];
    logic [4:0]  m_rd   [3];
    logic [4:0]  m_ff   [3];
    logic [63:0] m_data [3];
    int          m_wait [3];
    int          m_last;
    int          m_g;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic ird, input logic frd,
                       input logic [4:0] rd, input logic [4:0] ff, input logic [63:0] d);
        ifc.req_ird_w_v_i[i]     = ird;
        ifc.req_frd_w_v_i[i]     = frd;
        ifc.req_rd_addr_i[i*5 +: 5] = rd;
        ifc.req_fflags_i[i*5 +: 5]  = ff;
        ifc.req_data_i[i*64 +: 64]  = d;
    endtask

    task automatic model_comb(output exp_t e);
        logic elig [3];
        e = '{default: '0};
        m_g = -1;
        for (int i = 0; i < 3; i++)
            elig[i] = m_v[i] && !(m_ird[i] && ifc.iwb_port_busy_i) && !(m_frd[i] && ifc.fwb_port_busy_i);
        for (int i = 0; i < 3; i++)
            if (m_g < 0 && elig[i] && m_wait[i] == LIMIT) m_g = i;
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (m_last + k) % 3;
            if (m_g < 0 && elig[j]) m_g = j;
        end
        if (m_g >= 0) begin
            e.grant[m_g] = 1'b1;
            e.v    = 1'b1;
            e.yumi = 1'b1;
            e.ird  = m_ird[m_g];
            e.frd  = m_frd[m_g];
            e.rd   = m_rd[m_g];
            e.ff   = m_ff[m_g];
            e.data = m_data[m_g];
        end
        for (int i = 0; i < 3; i++) begin
            e.ready[i] = !m_v[i] || (m_g == i);
            if (m_v[i] && m_wait[i] == LIMIT) e.stall = 1'b1;
        end
    endtask

    task automatic model_seq(input logic [2:0] ready);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i]    = 1'b0;
                m_wait[i] = 0;
            end
            m_last = 2;
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic xfer;
                xfer = ifc.req_v_i[i] && ready[i];
                if (m_g == i || xfer) m_wait[i] = 0;
                else if (m_v[i] && m_wait[i] < LIMIT) m_wait[i] = m_wait[i] + 1;
                if (xfer) begin
                    m_v[i]    = 1'b1;
                    m_ird[i]  = ifc.req_ird_w_v_i[i];
                    m_frd[i]  = ifc.req_frd_w_v_i[i];
                    m_rd[i]   = ifc.req_rd_addr_i[i*5 +: 5];
                    m_ff[i]   = ifc.req_fflags_i[i*5 +: 5];
                    m_data[i] = ifc.req_data_i[i*64 +: 64];
                end else if (m_g == i) begin
                    m_v[i] = 1'b0;
                end
            end
            if (m_g >= 0) m_last = m_g;
        end
    endtask

    // Inputs are driven at the negedge before calling; outputs sampled 2 units later.
    task automatic cycle(input bit do_cmp);
        exp_t e;
        exp_t p;
        model_comb(e);
        if (do_cmp) exp_q.push_back(e);
        #2;
        snap.grant = ifc.late_wb_grant_o;
        snap.ready = ifc.req_ready_and_o;
        snap.v     = ifc.late_wb_v_o;
        snap.yumi  = ifc.late_wb_yumi_o;
        snap.ird   = ifc.late_wb_ird_w_v_o;
        snap.frd   = ifc.late_wb_frd_w_v_o;
        snap.stall = ifc.wb_stall_o;
        snap.rd    = ifc.late_wb_rd_addr_o;
        snap.ff    = ifc.late_wb_fflags_o;
        snap.data  = ifc.late_wb_data_o;
        if (do_cmp) begin
            p = exp_q.pop_front();
            check("sb_grant", 64'(snap.grant), 64'(p.grant));
            check("sb_ready", 64'(snap.ready), 64'(p.ready));
            check("sb_v",     64'(snap.v),     64'(p.v));
            check("sb_yumi",  64'(snap.yumi),  64'(p.yumi));
            check("sb_ird",   64'(snap.ird),   64'(p.ird));
            check("sb_frd",   64'(snap.frd),   64'(p.frd));
            check("sb_stall", 64'(snap.stall), 64'(p.stall));
            check("sb_rd",    64'(snap.rd),    64'(p.rd));
            check("sb_ff",    64'(snap.ff),    64'(p.ff));
            check("sb_data",  snap.data,       p.data);
        end
        model_seq(e.ready);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_wait[i] = 0; m_ird[i] = 1'b0; m_frd[i] = 1'b0;
            m_rd[i] = '0; m_ff[i] = '0; m_data[i] = '0;
        end
        m_last = 2;
        m_g    = -1;
        ifc.req_v_i = '0; ifc.req_ird_w_v_i = '0; ifc.req_frd_w_v_i = '0;
        ifc.req_rd_addr_i = '0; ifc.req_fflags_i = '0; ifc.req_data_i = '0;
        ifc.iwb_port_busy_i = 1'b0; ifc.fwb_port_busy_i = 1'b0;
        @(negedge clk);

        // reset held with all producers valid
        rst_n = 1'b0;
        ifc.req_v_i = 3'b111;
        put(0, 1'b1, 1'b0, 5'd1, 5'd0, 64'h100);
        put(1, 1'b0, 1'b1, 5'd2, 5'd3, 64'h200);
        put(2, 1'b1, 1'b0, 5'd3, 5'd0, 64'h300);
        cycle(0);
        cycle(1);
        cycle(1);
        check("rst_ready", 64'(snap.ready), 64'(3'b111));
        check("rst_v",     64'(snap.v),     64'(1'b0));
        check("rst_stall", 64'(snap.stall), 64'(1'b0));
        check("rst_grant", 64'(snap.grant), 64'(3'b000));

        // round-robin with every buffer refilled on its grant
        rst_n = 1'b1;
        cycle(1);
        check("load_v", 64'(snap.v), 64'(1'b0));
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 3; i++)
                put(i, ifc.req_ird_w_v_i[i], ifc.req_frd_w_v_i[i], 5'(i + 1), 5'd0, 64'(1000 + k * 10 + i));
            cycle(1);
            check("rr_grant",  64'(snap.grant), 64'(3'b001 << (k % 3)));
            check("rr_yumi",   64'(snap.yumi),  64'(1'b1));
            check("rr_refill", 64'(snap.ready), 64'(3'b001 << (k % 3)));
        end
        ifc.req_v_i = 3'b000;
        repeat (3) cycle(1);

        // port conflict: integer port busy, fdiv goes first
        ifc.req_v_i = 3'b011;
        put(0, 1'b1, 1'b0, 5'd5, 5'd0, 64'h55);
        put(1, 1'b0, 1'b1, 5'd7, 5'd1, 64'h77);
        cycle(1);
        ifc.req_v_i = 3'b000;
        ifc.iwb_port_busy_i = 1'b1;
        cycle(1);
        check("conf_grant", 64'(snap.grant), 64'(3'b010));
        check("conf_rd",    64'(snap.rd),    64'(5'd7));
        ifc.iwb_port_busy_i = 1'b0;
        cycle(1);
        check("conf_grant2", 64'(snap.grant), 64'(3'b001));
        check("conf_rd2",    64'(snap.rd),    64'(5'd5));

        // starvation of an integer idiv result
        ifc.iwb_port_busy_i = 1'b1;
        ifc.req_v_i = 3'b001;
        put(0, 1'b1, 1'b0, 5'd9, 5'd0, 64'h900);
        cycle(1);
        ifc.req_v_i = 3'b000;
        for (int k = 0; k < LIMIT; k++) begin
            if (k == LIMIT - 1) begin
                ifc.req_v_i = 3'b110;
                put(1, 1'b0, 1'b1, 5'd10, 5'd0, 64'hA00);
                put(2, 1'b0, 1'b0, 5'd11, 5'd0, 64'hB00);
            end
            cycle(1);
            check("starve_quiet", 64'(snap.stall), 64'(1'b0));
        end
        ifc.req_v_i = 3'b000;
        ifc.iwb_port_busy_i = 1'b0;
        cycle(1);
        check("starve_stall", 64'(snap.stall), 64'(1'b1));
        check("starve_grant", 64'(snap.grant), 64'(3'b001));
        cycle(1);
        check("starve_drop",  64'(snap.stall), 64'(1'b0));
        check("starve_next",  64'(snap.grant), 64'(3'b010));
        cycle(1);

        // drain-and-refill on the mem slot
        ifc.req_v_i = 3'b100;
        put(2, 1'b1, 1'b0, 5'd12, 5'd0, 64'h1111);
        cycle(1);
        put(2, 1'b1, 1'b0, 5'd13, 5'd0, 64'hDEAD);
        cycle(1);
        check("refill_grant", 64'(snap.grant),    64'(3'b100));
        check("refill_ready", 64'(snap.ready[2]), 64'(1'b1));
        check("refill_old",   snap.data,          64'h1111);
        ifc.req_v_i = 3'b000;
        cycle(1);
        check("refill_wait", 64'(dut.wait_cnt[2]), 64'(0));
        check("refill_new",  snap.data,            64'hDEAD);
        check("refill_rd",   64'(snap.rd),         64'(5'd13));

        // entry with no RF write drains even with both ports busy
        ifc.req_v_i = 3'b001;
        ifc.iwb_port_busy_i = 1'b1;
        ifc.fwb_port_busy_i = 1'b1;
        put(0, 1'b0, 1'b0, 5'd4, 5'd5, 64'hABC);
        cycle(1);
        ifc.req_v_i = 3'b000;
        cycle(1);
        check("nowr_v",   64'(snap.v),   64'(1'b1));
        check("nowr_ird", 64'(snap.ird), 64'(1'b0));
        check("nowr_frd", 64'(snap.frd), 64'(1'b0));
        cycle(1);
        check("nowr_empty", 64'(snap.v), 64'(1'b0));

        // random traffic, including busy stretches and occasional reset
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            ifc.req_v_i = 3'($urandom);
            for (int i = 0; i < 3; i++)
                put(i, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                    {32'($urandom), 32'($urandom)});
            if (((k / 40) % 2) == 1) begin
                ifc.iwb_port_busy_i = 1'b1;
                ifc.fwb_port_busy_i = ($urandom_range(0, 3) != 0);
            end else begin
                ifc.iwb_port_busy_i = 1'($urandom);
                ifc.fwb_port_busy_i = 1'($urandom);
            end
            cycle(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_be_late_wb_arbiter.md
Name: bp_be_late_wb_arbiter

Overview:
- Shares the single late-writeback port of the integer/FP register files between long-latency producers: idiv, fdiv and late memory fills.
- Holds one buffered result per producer and grants at most one per cycle.
- Only grants results whose register-file write port is free this cycle.
- Drives the late-writeback packet and yumi that clear the int/FP scoreboards; raises an issue stall when any producer starves.

Parameters:
- num_req_p, 3, number of producers; index 0 idiv, 1 fdiv, 2 late mem.
- data_width_p, 64, result data width.
- starve_limit_p, 8, cycles a buffered result may wait before forced priority; must be ≥1, ≤255.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, synchronous, active-low.
- req_v_i  in  num_req_p  producer result valid.
- req_ready_and_o  out  num_req_p  producer may present (ready-and handshake: transfer when v & ready).
- req_ird_w_v_i  in  num_req_p  result writes integer RF.
- req_frd_w_v_i  in  num_req_p  result writes FP RF.
- req_rd_addr_i  in  num_req_p*5  destination register.
- req_fflags_i  in  num_req_p*5  FP exception flags.
- req_data_i  in  num_req_p*data_width_p  result data.
- iwb_port_busy_i  in  1  main pipe owns integer write port this cycle.
- fwb_port_busy_i  in  1  main pipe owns FP write port this cycle.
- late_wb_v_o  out  1  a late writeback is performed this cycle.
- late_wb_ird_w_v_o  out  1  granted entry writes integer RF.
- late_wb_frd_w_v_o  out  1  granted entry writes FP RF.
- late_wb_rd_addr_o  out  5  granted destination.
- late_wb_fflags_o  out  5  granted flags.
- late_wb_data_o  out  data_width_p  granted data.
- late_wb_yumi_o  out  1  equals late_wb_v_o; consumed by the scoreboard clear.
- late_wb_grant_o  out  num_req_p  one-hot grant, for debug/cosim.
- wb_stall_o  out  1  some entry reached starve_limit_p; issue must hold.

Behaviour:
- State per producer i:
  - buf_v[i]: entry valid.
  - buf payload.
  - wait_cnt[i]: 8-bit, saturating at starve_limit_p.
- Global state: last_grant pointer of width clog2(num_req_p).
- Reset (reset_n_i low at posedge):
  - all buf_v = 0, wait_cnt = 0, last_grant = num_req_p-1.
  - Outputs during and after reset until a request is buffered: late_wb_v_o = 0, yumi = 0, grant = 0, wb_stall_o = 0.
  - req_ready_and_o = all ones.
  - Reset mid-operation discards buffered results; producers are flushed by the same reset.
- Eligibility: elig[i] = buf_v[i] & ~(ird_w_v[i] & iwb_port_busy_i) & ~(frd_w_v[i] & fwb_port_busy_i).
  - An entry with both write flags low is always eligible and drains with late_wb_v_o = 1; both w_v outputs are low, so the scoreboard ignores it.
- Selection, combinational from registered buffers:
  - If any eligible entry has wait_cnt == starve_limit_p, grant the lowest such index.
  - Otherwise grant round-robin among eligible entries, starting at last_grant+1 modulo num_req_p.
  - At most one grant per cycle.
- Outputs are muxed from the granted entry. With no grant, late_wb_v_o = 0 and the payload outputs are 0.
- Handshake:
  - req_ready_and_o[i] = ~buf_v[i] | grant[i]; same-cycle drain-and-refill is allowed.
  - A transfer loads the payload and sets buf_v. A grant without a transfer clears buf_v.
- Latency: a result accepted at edge N appears on late_wb_v_o no earlier than cycle N+1 (one registered stage).
- Pointer: on a grant, last_grant <= granted index; starved grants also update it.
- Counters:
  - wait_cnt[i] increments when buf_v[i] & ~grant[i], saturating.
  - It clears to 0 on grant or on an empty-to-load transition.
  - On grant+refill in the same cycle it loads 0.
- wb_stall_o = OR over i of (buf_v[i] & wait_cnt[i] == starve_limit_p); it is a registered-state function, with no input-to-output path.
- Both ports busy with every entry needing a port: no grant; counters advance; stall asserts after starve_limit_p cycles.
- rd_addr x0 with ird_w_v set is passed through unchanged; the RF ignores x0.

Decomposition:
- Shared package bp_be_pkg gains:
  - enum bp_be_late_wb_src_e {e_late_wb_idiv = 0, e_late_wb_fdiv = 1, e_late_wb_mem = 2}.
  - struct bp_be_late_wb_entry_s {ird_w_v, frd_w_v, rd_addr[4:0], fflags[4:0], data}.
- Sub-module bp_be_late_wb_rr_sel: combinational round-robin select with priority-override vector. Inputs: elig, starved, last_grant. Output: one-hot grant.
- Buffers, counters and the pointer stay in the top module.

Test Plan:
- Reset: hold reset_n_i low 3 cycles with req_v_i = 3'b111 → ready = 3'b111, late_wb_v_o = 0, wb_stall_o = 0; the first post-reset grant of all-valid entries is index 0.
- Round-robin: keep all three buffers refilled every cycle, ports free → grants 0,1,2,0,1,2; yumi high each cycle; each refill is accepted on its grant cycle.
- Port conflict: idiv (ird_w_v = 1, rd = 5) and fdiv (frd_w_v = 1, rd = 7) buffered, iwb_port_busy_i = 1 → fdiv granted, rd_addr_o = 7; idiv granted the next cycle once busy drops.
- Starvation: starve_limit_p = 8; iwb_port_busy_i held high with an idiv int entry buffered → wb_stall_o rises after 8 waiting cycles. On busy release, idiv is granted even while fdiv/mem are eligible, and stall drops the next cycle.
- Drain-and-refill: mem entry granted while req_v_i[2] = 1 with new data 0xDEAD → ready[2] = 1, the new entry is valid the next cycle, and wait_cnt[2] = 0.
- No-write entry: ird_w_v = frd_w_v = 0 buffered → late_wb_v_o = 1 for one cycle with both w_v outputs 0; the buffer empties.
